// File: rtl/neuron_serial_integrator.sv
// Serial leaky integrate-and-fire neuron: integrates AXON_CHUNK axons per cycle
// over NUM_AXONS/AXON_CHUNK cycles, then applies leak, thresholds and reset rule.
module neuron_serial_integrator #(
  parameter int NUM_AXONS       = 256,
  parameter int AXON_CHUNK      = 16,
  parameter int NUM_WEIGHTS     = 4,
  parameter int WEIGHT_WIDTH    = 9,
  parameter int LEAK_WIDTH      = 9,
  parameter int THRESHOLD_WIDTH = 9,
  parameter int POTENTIAL_WIDTH = 9,
  parameter int COUNT_WIDTH     = 16,
  localparam int TW = $clog2(NUM_WEIGHTS)
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic                                start_i,
  input  logic [POTENTIAL_WIDTH-1:0]          current_potential_i,
  input  logic [LEAK_WIDTH-1:0]               leak_i,
  input  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] weights_i,
  input  logic [NUM_AXONS*TW-1:0]             axon_type_i,
  input  logic [NUM_AXONS-1:0]                synapses_in_i,
  input  logic [NUM_AXONS-1:0]                axon_in_i,
  input  logic [THRESHOLD_WIDTH-1:0]          positive_threshold_i,
  input  logic [THRESHOLD_WIDTH-1:0]          negative_threshold_i,
  input  logic [POTENTIAL_WIDTH-1:0]          reset_potential_i,
  input  logic                                reset_mode_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic                                spike_o,
  output logic [POTENTIAL_WIDTH-1:0]          write_potential_o,
  output logic [COUNT_WIDTH-1:0]              spike_count_o
);

  localparam int K     = NUM_AXONS / AXON_CHUNK;
  localparam int CW    = (K > 1) ? $clog2(K) : 1;
  localparam int P     = POTENTIAL_WIDTH;
  localparam int ACC_W = ((P > WEIGHT_WIDTH) ? P : WEIGHT_WIDTH) + $clog2(NUM_AXONS) + 2;
  localparam int MAX_A = (ACC_W > LEAK_WIDTH) ? ACC_W : LEAK_WIDTH;
  localparam int V_W   = ((MAX_A > THRESHOLD_WIDTH) ? MAX_A : THRESHOLD_WIDTH) + 2;

  localparam logic signed [V_W-1:0] POT_MAX = {{(V_W-P+1){1'b0}}, {(P-1){1'b1}}};
  localparam logic signed [V_W-1:0] POT_MIN = {{(V_W-P+1){1'b1}}, {(P-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, ACCUM, FIRE, DONE} state_t;
  state_t state_reg, state_next;

  logic [NUM_AXONS-1:0]                active_reg;
  logic [NUM_AXONS*TW-1:0]             type_reg;
  logic [NUM_WEIGHTS*WEIGHT_WIDTH-1:0] weights_reg;
  logic [LEAK_WIDTH-1:0]               leak_reg;
  logic [THRESHOLD_WIDTH-1:0]          pos_reg, neg_reg;
  logic [P-1:0]                        reset_pot_reg;
  logic                                mode_reg;
  logic [CW-1:0]                       chunk_reg;
  logic signed [ACC_W-1:0]             acc_reg;
  logic                                spike_reg, spike_next;
  logic [P-1:0]                        write_reg, write_next;
  logic [COUNT_WIDTH-1:0]              count_reg;

  logic                                last_chunk;
  logic signed [ACC_W-1:0]             chunk_sum;
  logic signed [WEIGHT_WIDTH-1:0]      weight_arr [NUM_WEIGHTS];
  logic signed [ACC_W-1:0]             term [AXON_CHUNK];
  logic signed [V_W-1:0]               acc_ext, leak_ext, pos_ext, neg_ext, v, over;

  assign last_chunk = (chunk_reg == CW'(K-1));
  assign busy_o     = (state_reg != IDLE);
  assign done_o     = (state_reg == DONE);
  assign spike_o           = spike_reg;
  assign write_potential_o = write_reg;
  assign spike_count_o     = count_reg;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start_i) state_next = ACCUM;
      ACCUM:   if (last_chunk) state_next = FIRE;
      FIRE:    state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_WEIGHTS; gi++) begin : g_weight
      assign weight_arr[gi] = weights_reg[gi*WEIGHT_WIDTH +: WEIGHT_WIDTH];
    end
    // Mask and type registers shift down one chunk per cycle, so the current chunk is always the low slice.
    for (gi = 0; gi < AXON_CHUNK; gi++) begin : g_term
      logic signed [WEIGHT_WIDTH-1:0] w;
      assign w        = weight_arr[type_reg[gi*TW +: TW]];
      assign term[gi] = active_reg[gi] ? {{(ACC_W-WEIGHT_WIDTH){w[WEIGHT_WIDTH-1]}}, w} : '0;
    end
  endgenerate

  always_comb begin
    chunk_sum = '0;
    for (int i = 0; i < AXON_CHUNK; i++) chunk_sum = chunk_sum + term[i];
  end

  assign acc_ext  = {{(V_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg};
  assign leak_ext = {{(V_W-LEAK_WIDTH){leak_reg[LEAK_WIDTH-1]}}, leak_reg};
  assign pos_ext  = {{(V_W-THRESHOLD_WIDTH){pos_reg[THRESHOLD_WIDTH-1]}}, pos_reg};
  assign neg_ext  = {{(V_W-THRESHOLD_WIDTH){neg_reg[THRESHOLD_WIDTH-1]}}, neg_reg};
  assign v        = acc_ext + leak_ext;
  assign over     = v - pos_ext;

  function automatic logic [P-1:0] sat(input logic signed [V_W-1:0] x);
    if (x > POT_MAX)      return POT_MAX[P-1:0];
    else if (x < POT_MIN) return POT_MIN[P-1:0];
    else                  return x[P-1:0];
  endfunction

  always_comb begin
    spike_next = 1'b0;
    write_next = sat(v);
    if (v >= pos_ext) begin
      spike_next = 1'b1;
      write_next = mode_reg ? sat(over) : reset_pot_reg;
    end else if (v < neg_ext) begin
      write_next = mode_reg ? sat(neg_ext) : reset_pot_reg;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      active_reg    <= '0;
      type_reg      <= '0;
      weights_reg   <= '0;
      leak_reg      <= '0;
      pos_reg       <= '0;
      neg_reg       <= '0;
      reset_pot_reg <= '0;
      mode_reg      <= 1'b0;
      chunk_reg     <= '0;
      acc_reg       <= '0;
      spike_reg     <= 1'b0;
      write_reg     <= '0;
      count_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: if (start_i) begin
          active_reg    <= axon_in_i & synapses_in_i;
          type_reg      <= axon_type_i;
          weights_reg   <= weights_i;
          leak_reg      <= leak_i;
          pos_reg       <= positive_threshold_i;
          neg_reg       <= negative_threshold_i;
          reset_pot_reg <= reset_potential_i;
          mode_reg      <= reset_mode_i;
          chunk_reg     <= '0;
          acc_reg       <= {{(ACC_W-P){current_potential_i[P-1]}}, current_potential_i};
        end
        ACCUM: begin
          acc_reg    <= acc_reg + chunk_sum;
          chunk_reg  <= chunk_reg + CW'(1);
          active_reg <= active_reg >> AXON_CHUNK;
          type_reg   <= type_reg >> (AXON_CHUNK*TW);
        end
        FIRE: begin
          spike_reg <= spike_next;
          write_reg <= write_next;
          if (spike_next) count_reg <= count_reg + COUNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_serial_integrator.sv
// Directed bench for neuron_serial_integrator: default instance plus a
// 4-bit spike counter instance sharing the same stimulus.
module tb_neuron_serial_integrator;

  localparam int NA = 256;
  localparam int NW = 4;
  localparam int W  = 9;
  localparam int P  = 9;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic [P-1:0]      current_potential, reset_potential;
  logic [8:0]        leak, pos_thr, neg_thr;
  logic [NW*W-1:0]   weights;
  logic [NA*2-1:0]   axon_type;
  logic [NA-1:0]     synapses, axons;
  logic              reset_mode;

  logic              busy, done, spike;
  logic [P-1:0]      write_pot;
  logic [15:0]       count;
  logic              busy4, done4, spike4;
  logic [P-1:0]      write4;
  logic [3:0]        count4;

  always #5 clk = ~clk;

  neuron_serial_integrator dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .current_potential_i(current_potential), .leak_i(leak), .weights_i(weights),
    .axon_type_i(axon_type), .synapses_in_i(synapses), .axon_in_i(axons),
    .positive_threshold_i(pos_thr), .negative_threshold_i(neg_thr),
    .reset_potential_i(reset_potential), .reset_mode_i(reset_mode),
    .busy_o(busy), .done_o(done), .spike_o(spike),
    .write_potential_o(write_pot), .spike_count_o(count)
  );

  neuron_serial_integrator #(.COUNT_WIDTH(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
    .current_potential_i(current_potential), .leak_i(leak), .weights_i(weights),
    .axon_type_i(axon_type), .synapses_in_i(synapses), .axon_in_i(axons),
    .positive_threshold_i(pos_thr), .negative_threshold_i(neg_thr),
    .reset_potential_i(reset_potential), .reset_mode_i(reset_mode),
    .busy_o(busy4), .done_o(done4), .spike_o(spike4),
    .write_potential_o(write4), .spike_count_o(count4)
  );

  int checks = 0;
  int failures = 0;
  int exp_count = 0;
  int r_lat, r_busy, r_dones, r_spike, r_write, r_count, r_count4;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_spike"}, int'(spike), 0);
    check({tag, "_write"}, int'(write_pot), 0);
    check({tag, "_count"}, int'(count), 0);
    check({tag, "_count4"}, int'(count4), 0);
  endtask

  task automatic set_base();
    current_potential = '0;
    reset_potential   = '0;
    leak       = '0;
    pos_thr    = 9'(100);
    neg_thr    = 9'(-100);
    weights    = '0;
    axon_type  = '0;
    synapses   = '0;
    axons      = '0;
    reset_mode = 1'b0;
  endtask

  task automatic set_weight(input int t, input int val);
    weights[t*W +: W] = 9'(val);
  endtask

  task automatic set_axon(input int j, input int t, input logic a, input logic s);
    axon_type[j*2 +: 2] = 2'(t);
    axons[j]    = a;
    synapses[j] = s;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero_outputs("reset_pulse");
    @(negedge clk);
    rst_n = 1'b1;
    exp_count = 0;
  endtask

  // Starts one operation, scrambles the data inputs after capture and
  // watches a fixed 40-cycle window; optional extra start / reset injection.
  task automatic run_op(input string name, input int extra_start_at, input int rst_at);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    current_potential = 9'($urandom);
    leak      = 9'($urandom);
    weights   = 36'({$urandom, $urandom});
    axon_type = {16{$urandom}};
    axons     = {8{$urandom}};
    synapses  = {8{$urandom}};
    pos_thr   = 9'($urandom);
    neg_thr   = 9'($urandom);
    r_lat   = -1;
    r_busy  = busy ? 1 : 0;
    r_dones = 0;
    r_spike = -1; r_write = -999; r_count = -1; r_count4 = -1;
    for (int i = 1; i <= 40; i++) begin
      if (i == extra_start_at) start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      if (busy) r_busy++;
      if (done) begin
        r_dones++;
        if (r_lat < 0) begin
          r_lat    = i;
          r_spike  = int'(spike);
          r_write  = int'($signed(write_pot));
          r_count  = int'(count);
          r_count4 = int'(count4);
        end
      end
      if (i == rst_at) begin
        rst_n = 1'b0;
        #1;
        check_zero_outputs({name, "_midreset"});
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    $display("op %s: lat=%0d busy=%0d dones=%0d spike=%0d write=%0d count=%0d count4=%0d",
             name, r_lat, r_busy, r_dones, r_spike, r_write, r_count, r_count4);
  endtask

  task automatic expect_result(input string name, input int exp_spike, input int exp_write);
    if (exp_spike != 0) exp_count++;
    check({name, "_latency"}, r_lat, 17);
    check({name, "_dones"}, r_dones, 1);
    check({name, "_spike"}, r_spike, exp_spike);
    check({name, "_write"}, r_write, exp_write);
    check({name, "_count"}, r_count, exp_count % 65536);
    check({name, "_count4"}, r_count4, exp_count % 16);
    check({name, "_hold_write"}, int'($signed(write_pot)), exp_write);
    check({name, "_hold_spike"}, int'(spike), exp_spike);
  endtask

  initial begin
    set_base();
    #12;
    check_zero_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    set_base();
    current_potential = 9'(10); leak = 9'(-3);
    run_op("no_axons", -1, -1);
    expect_result("no_axons", 0, 7);
    check("no_axons_busy_cycles", r_busy, 18);

    for (int m = 0; m < 2; m++) begin
      set_base();
      set_weight(0, -7); set_weight(1, 50); set_weight(2, 30); set_weight(3, 99);
      set_axon(0, 2, 1'b1, 1'b1);   set_axon(17, 2, 1'b1, 1'b1);
      set_axon(100, 2, 1'b1, 1'b1); set_axon(255, 2, 1'b1, 1'b1);
      set_axon(20, 3, 1'b1, 1'b0);  set_axon(40, 1, 1'b0, 1'b1);
      reset_mode = 1'(m);
      run_op(m == 0 ? "four_axons_abs" : "four_axons_lin", -1, -1);
      expect_result(m == 0 ? "four_axons_abs" : "four_axons_lin", 1, m == 0 ? 0 : 20);
    end

    set_base();
    weights = {4{9'h0FF}};
    axons = '1; synapses = '1; axon_type = {16{$urandom}};
    current_potential = 9'(255); pos_thr = 9'(255); reset_mode = 1'b1;
    run_op("sat_high", -1, -1);
    expect_result("sat_high", 1, 255);

    for (int m = 0; m < 2; m++) begin
      set_base();
      weights = {4{9'h100}};
      axons = '1; synapses = '1; axon_type = {16{$urandom}};
      current_potential = 9'(-256); neg_thr = 9'(-256); pos_thr = 9'(255);
      reset_potential = 9'(5); reset_mode = 1'(m);
      run_op(m == 0 ? "sat_low_abs" : "sat_low_lin", -1, -1);
      expect_result(m == 0 ? "sat_low_abs" : "sat_low_lin", 0, m == 0 ? 5 : -256);
    end

    for (int m = 0; m < 2; m++) begin
      set_base();
      current_potential = 9'(-90); leak = 9'(-20);
      reset_potential = 9'(5); reset_mode = 1'(m);
      run_op(m == 0 ? "floor_abs" : "floor_lin", -1, -1);
      expect_result(m == 0 ? "floor_abs" : "floor_lin", 0, m == 0 ? 5 : -100);
    end

    set_base();
    current_potential = 9'(100); reset_mode = 1'b1;
    run_op("eq_pos", -1, -1);
    expect_result("eq_pos", 1, 0);

    set_base();
    current_potential = 9'(-100); reset_potential = 9'(5);
    run_op("eq_neg", -1, -1);
    expect_result("eq_neg", 0, -100);

    set_base();
    set_weight(1, -40); set_weight(3, 25);
    for (int j = 3; j <= 5; j++) set_axon(j, 1, 1'b1, 1'b1);
    for (int j = 130; j <= 134; j++) set_axon(j, 3, 1'b1, 1'b1);
    current_potential = 9'(20); leak = 9'(4);
    run_op("mixed_sign", -1, -1);
    expect_result("mixed_sign", 0, 29);

    set_base();
    current_potential = 9'(10); leak = 9'(-3);
    run_op("extra_start", 5, -1);
    expect_result("extra_start", 0, 7);

    set_base();
    current_potential = 9'(100);
    run_op("mid_reset", -1, 5);
    check("mid_reset_dones", r_dones, 0);
    exp_count = 0;

    set_base();
    current_potential = 9'(100);
    run_op("post_reset", -1, -1);
    expect_result("post_reset", 1, 0);

    pulse_reset();
    for (int n = 0; n < 16; n++) begin
      set_base();
      current_potential = 9'(100);
      run_op("wrap", -1, -1);
      exp_count++;
    end
    check("wrap_count4", int'(count4), 0);
    check("wrap_count16", int'(count), 16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/neuron_serial_integrator.md
NEURON_SERIAL_INTEGRATOR -- requirements
Module: neuron_serial_integrator

Interface
REQ-001 The block SHALL have parameter NUM_AXONS, default 256, giving the axon count.
REQ-002 The block SHALL have parameter AXON_CHUNK, default 16, giving axons integrated per cycle; NUM_AXONS SHALL be a multiple of it. K = NUM_AXONS/AXON_CHUNK.
REQ-003 The block SHALL have parameter NUM_WEIGHTS, default 4, giving the number of weight types; it SHALL be a power of 2 and at least 2. TW = clog2(NUM_WEIGHTS).
REQ-004 The block SHALL have parameters WEIGHT_WIDTH, LEAK_WIDTH, THRESHOLD_WIDTH and POTENTIAL_WIDTH, each default 9, all signed two's complement.
REQ-005 The block SHALL have parameter COUNT_WIDTH, default 16, giving the spike counter width.
REQ-006 Ports SHALL be as follows; there is one clock, and reset is asynchronous and active-low:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- start_i  in  1  request to integrate one neuron
- current_potential_i  in  POTENTIAL_WIDTH  stored potential
- leak_i  in  LEAK_WIDTH  leak added after integration
- weights_i  in  NUM_WEIGHTS*WEIGHT_WIDTH  weight table; type t is at slice t
- axon_type_i  in  NUM_AXONS*TW  per-axon weight type
- synapses_in_i  in  NUM_AXONS  crossbar row
- axon_in_i  in  NUM_AXONS  axon spikes
- positive_threshold_i  in  THRESHOLD_WIDTH  firing threshold
- negative_threshold_i  in  THRESHOLD_WIDTH  floor threshold
- reset_potential_i  in  POTENTIAL_WIDTH  reset value
- reset_mode_i  in  1  0 = absolute, 1 = linear
- busy_o  out  1  state is not IDLE
- done_o  out  1  one-cycle result strobe
- spike_o  out  1  fired; valid while done_o is high, held until the next done_o
- write_potential_o  out  POTENTIAL_WIDTH  new potential; valid while done_o is high, held until the next done_o
- spike_count_o  out  COUNT_WIDTH  spikes since reset

Function
REQ-007 The FSM SHALL have states IDLE, ACCUM, FIRE and DONE.
REQ-008 In IDLE with start_i=1, the block SHALL capture all data inputs into registers on that edge, load the accumulator with sign-extended current_potential_i, clear the chunk index, and go to ACCUM.
REQ-009 start_i SHALL be ignored in any state other than IDLE. Data inputs SHALL be don't-care after capture.
REQ-010 In ACCUM, each cycle SHALL add, for every axon j in chunk c, weights[axon_type[j]] when axon_in[j] & synapses_in[j] is 1, else 0.
REQ-011 In ACCUM, the chunk index c SHALL increment each cycle; after chunk K-1 the FSM SHALL go to FIRE.
REQ-012 The accumulator SHALL be max(POTENTIAL_WIDTH, WEIGHT_WIDTH) + clog2(NUM_AXONS) + 2 bits wide, so that it never overflows.
REQ-013 In FIRE, the block SHALL compute v = acc + sext(leak), compare it against the sign-extended thresholds, and go to DONE.
REQ-014 Result rules, with v >= pos taking priority over v < neg:
- If v >= pos: spike=1; mode 0 gives write = reset_potential; mode 1 gives write = sat(v - pos).
- Else if v < neg: spike=0; mode 0 gives write = reset_potential; mode 1 gives write = sat(neg).
- Otherwise: spike=0; write = sat(v).
REQ-015 sat() SHALL clamp to the signed POTENTIAL_WIDTH range [-2^(P-1), 2^(P-1)-1].
REQ-016 The FSM SHALL move from FIRE to DONE on the same edge that registers spike_o and write_potential_o. done_o SHALL be 1 only in DONE, and DONE SHALL go to IDLE on the next edge.
REQ-017 Latency: if start is accepted at edge 0, done_o SHALL be high in the cycle after edge K+1. A new start SHALL be accepted no earlier than edge K+3.
REQ-018 spike_count_o SHALL increment when the block enters DONE with spike=1 and SHALL wrap from all-ones to 0.

Reset
REQ-019 While rst_n_i=0, the block SHALL asynchronously force state=IDLE and accumulator=0, and drive busy_o=0, done_o=0, spike_o=0, write_potential_o=0 and spike_count_o=0.
REQ-020 Reset during ACCUM or FIRE SHALL discard the in-flight operation with no done_o. The first start after reset release SHALL behave per REQ-008.

Verification (default parameters, K=16)
REQ-021 No active axons, current=10, leak=-3, pos=100, neg=-100: done_o high 17 cycles after the start edge, spike=0, write=7, busy_o high for 18 cycles.
REQ-022 Four active axons of type 2, with weights[2]=30, current=0, leak=0, pos=100, reset_potential=0: mode 0 gives spike=1 and write=0; mode 1 gives spike=1 and write=20; spike_count increments by 1 each time.
REQ-023 Saturation: all 256 axons active, all weights 255, current=255, pos=255, mode 1: spike=1, write=255. With all weights -256, current=-256, neg=-256, mode 0, reset_potential=5: spike=0, write=5.
REQ-024 Negative floor: current=-90, leak=-20, neg=-100: mode 0 with reset_potential=5 gives write=5; mode 1 gives write=-100; spike=0 in both cases.
REQ-025 Protocol: start_i pulsed during ACCUM is ignored and only one done_o results. rst_n_i asserted at ACCUM cycle 5 gives all outputs 0 and no done_o; a following start completes normally with spike_count reflecting only post-reset spikes.
REQ-026 With COUNT_WIDTH=4, 16 consecutive spiking operations return spike_count_o to 0.
